writeback_unit: RTL
===================

Name: writeback_unit

Overview:
- Writeback stage directly upstream of the 64-entry, 64-bit regfile; owns its single write port (write_enable/write_addr/write_data).
- Merges results from the single-cycle ALU path and the variable-latency memory (load) path.
- Buffers load results in a small FIFO and arbitrates one register write per cycle.
- Maintains the pending-destination scoreboard that the operand-fetch stage uses for RAW stalls.

Parameters:
XLEN, 64, datapath width
AREG_W, 6, register address width (2**AREG_W registers)
LQ_DEPTH, 4, load-result FIFO depth (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle (combinational)
alu_rd  in  AREG_W  ALU destination
alu_data  in  XLEN  ALU result
mem_valid  in  1  load result present
mem_ready  out  1  load FIFO can accept (registered-state only)
mem_rd  in  AREG_W  load destination
mem_data  in  XLEN  load result
alloc_valid  in  1  issue marks a destination pending
alloc_rd  in  AREG_W  destination being allocated
rf_write_enable  out  1  to regfile write_enable
rf_write_addr  out  AREG_W  to regfile write_addr
rf_write_data  out  XLEN  to regfile write_data
pend_mask  out  2**AREG_W  bit i = register i awaiting writeback
lq_count  out  clog2(LQ_DEPTH)+1  FIFO occupancy (debug)

Behaviour:
- Reset (async, rst_n=0): FIFO empty, lq_count=0, rf_write_enable=0, rf_write_addr=0, rf_write_data=0, pend_mask=0. Reset mid-operation drops all buffered results.
- mem_ready = (lq_count != LQ_DEPTH); push on mem_valid & mem_ready. mem_ready does not depend on same-cycle pop.
- Arbitration, evaluated each cycle:
  1. FIFO full: FIFO head wins; alu_ready=0.
  2. Else if alu_valid: ALU wins; alu_ready=1.
  3. Else if FIFO non-empty: FIFO head wins.
  4. Else: idle.
- alu_ready = (lq_count != LQ_DEPTH), independent of alu_valid.
- Push and pop in the same cycle are allowed when not full; lq_count is unchanged. Empty FIFO plus push: entry visible at head the next cycle, with no fall-through.
- Output register: the winner loads rf_write_addr/rf_write_data at the next edge.
  - rf_write_enable=1 iff a winner existed and winner rd != 0.
  - rd==0 results are consumed (handshake completes, FIFO pops) but never written.
  - Idle: rf_write_enable=0; addr and data hold their last values.
- Latency: 1 cycle from acceptance to rf_write_enable. The regfile commits at the following edge.
- Scoreboard (pend_mask):
  - At an edge with rf_write_enable=1: clear bit rf_write_addr. The bit drops at the same edge the regfile captures the data.
  - At an edge with alloc_valid=1 and alloc_rd!=0: set bit alloc_rd.
  - Same register set and cleared on one edge: set wins (newer allocation).
  - Bit 0 is constantly 0.
  - Duplicate alloc of an already-pending register keeps the bit at 1 (no counting).
- FIFO pointers are AREG-independent, log2(LQ_DEPTH) bits wide, and wrap modulo LQ_DEPTH. Order is strict FIFO.
- No result is ever dropped or duplicated. The ALU never stalls while the FIFO is not full.

Decomposition:
- Package wb_pkg holds:
  - XLEN, AREG_W, NUM_REGS=2**AREG_W;
  - typedef wb_result_t {rd, data};
  - enum wb_src_e {WB_NONE, WB_ALU, WB_LQ}.
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_result_t. Ports: push, pop, full, empty, count, head.
- Arbitration, output register and scoreboard live in writeback_unit.

Test Plan:
- Reset, then ALU alu_rd=1 data=AAAAAAAAAAAAAAAA for one cycle.
  -> Next cycle rf_write_enable=1, addr=1, data=AAAA…AA; alu_ready=1 throughout.
- alloc rd=3, then load rd=3 data=DEADBEEFCAFEBABE with no ALU traffic.
  -> pend_mask[3]=1 until the edge with rf_write_enable=1, addr=3; cleared after that edge.
- ALU rd=2 every cycle while pushing 4 loads rd=4..7.
  -> FIFO reaches full, lq_count=4, mem_ready=0, alu_ready=0.
  -> Head rd=4 is written next, then ALU resumes; all of rd 4–7 are written in order and none lost.
- ALU rd=0 data=FFFFFFFFFFFFFFFF, and load rd=0.
  -> Both handshakes complete; rf_write_enable stays 0; pend_mask[0] stays 0.
- Same edge: alloc rd=5 and rf_write_enable=1 with addr=5 -> pend_mask[5]=1 afterwards.
- Reset asserted mid-stream with 3 loads buffered.
  -> lq_count=0, rf_write_enable=0, pend_mask=0 immediately (asynchronous).
  -> After release, no stale writes appear.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage:
// widths, the result bundle and the winner select.
package wb_pkg;
  localparam int XLEN     = 64;
  localparam int AREG_W   = 6;
  localparam int NUM_REGS = 2**AREG_W;

  typedef struct packed {
    logic [AREG_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_result_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LQ
  } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO: strict order, head valid
// one cycle after push, no fall-through.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  wb_result_t    push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output wb_result_t    head
);

  wb_result_t    mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU and load results
// onto the regfile write port and tracks pending rds.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  localparam int CW = $clog2(LQ_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [AREG_W-1:0]   alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [AREG_W-1:0]   mem_rd,
  input  logic [XLEN-1:0]     mem_data,
  input  logic                alloc_valid,
  input  logic [AREG_W-1:0]   alloc_rd,
  output logic                rf_write_enable,
  output logic [AREG_W-1:0]   rf_write_addr,
  output logic [XLEN-1:0]     rf_write_data,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic [CW-1:0]       lq_count
);

  wb_result_t          alu_res;
  wb_result_t          mem_res;
  wb_result_t          head;
  wb_result_t          win;
  wb_src_e             src;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  logic                we_q, we_d;
  logic [AREG_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     data_q, data_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;

  assign alu_res   = '{rd: alu_rd, data: alu_data};
  assign mem_res   = '{rd: mem_rd, data: mem_data};
  assign alu_ready = ~full;
  assign mem_ready = ~full;
  assign push      = mem_valid & ~full;
  assign pop       = (src == WB_LQ);

  wb_fifo #(
    .DEPTH(LQ_DEPTH)
  ) u_lq (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(mem_res),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .count    (lq_count),
    .head     (head)
  );

  // A full queue drains first so the ALU is never starved for long.
  always_comb begin
    src = WB_NONE;
    win = head;
    unique case (1'b1)
      full:                       src = WB_LQ;
      !full && alu_valid: begin
        src = WB_ALU;
        win = alu_res;
      end
      !full && !alu_valid && !empty: src = WB_LQ;
      default:                    src = WB_NONE;
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (src != WB_NONE) begin
      addr_d = win.rd;
      data_d = win.data;
      we_d   = |win.rd;
    end
    pend_d = pend_q;
    if (we_q) pend_d[addr_q] = 1'b0;
    if (alloc_valid && |alloc_rd) pend_d[alloc_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      pend_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = addr_q;
  assign rf_write_data   = data_q;
  assign pend_mask       = pend_q;

endmodule
